vedic_mul8_seq: RTL

VEDIC_MUL8_SEQ -- requirements
Module: vedic_mul8_seq

---
 rtl/vedic_mul8_seq_if.sv | 22 ++
 rtl/vedic_mul8_seq.sv | 105 ++++++++++
 2 files changed

// File: rtl/vedic_mul8_seq_if.sv
// rtl/vedic_mul8_seq_if.sv - request, nibble-multiplier and result signals of vedic_mul8_seq
interface vedic_mul8_seq_if;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [3:0]  mul_a;
  logic [3:0]  mul_b;
  logic [7:0]  mul_p;
  logic        busy;
  logic        done;
  logic [15:0] product;

  modport master (
    output start, a, b, mul_p,
    input  mul_a, mul_b, busy, done, product
  );

  modport slave (
    input  start, a, b, mul_p,
    output mul_a, mul_b, busy, done, product
  );
endinterface

// File: rtl/vedic_mul8_seq.sv
// rtl/vedic_mul8_seq.sv - 8x8 unsigned multiply built from four passes through one external 4x4 multiplier
module vedic_mul8_seq (
  input  logic               clk,
  input  logic               rst_n,
  vedic_mul8_seq_if.slave    bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PP0  = 3'd1,
    ST_PP1  = 3'd2,
    ST_PP2  = 3'd3,
    ST_PP3  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  a_r_q, a_r_d;
  logic [7:0]  b_r_q, b_r_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] product_q, product_d;
  logic        done_q, done_d;

  logic [3:0]  mul_a_c;
  logic [3:0]  mul_b_c;
  logic [15:0] pp_ext;

  // Partial products are zero-extended before shifting so no carry is lost.
  assign pp_ext = {8'h00, bus.mul_p};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_r_q     <= 8'h00;
      b_r_q     <= 8'h00;
      acc_q     <= 16'h0000;
      product_q <= 16'h0000;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_r_q     <= a_r_d;
      b_r_q     <= b_r_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_r_d     = a_r_q;
    b_r_d     = b_r_q;
    acc_d     = acc_q;
    product_d = product_q;
    done_d    = 1'b0;
    mul_a_c   = 4'h0;
    mul_b_c   = 4'h0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_r_d   = bus.a;
          b_r_d   = bus.b;
          acc_d   = 16'h0000;
          state_d = ST_PP0;
        end
      end
      ST_PP0: begin
        mul_a_c = a_r_q[3:0];
        mul_b_c = b_r_q[3:0];
        acc_d   = acc_q + pp_ext;
        state_d = ST_PP1;
      end
      ST_PP1: begin
        mul_a_c = a_r_q[3:0];
        mul_b_c = b_r_q[7:4];
        acc_d   = acc_q + (pp_ext << 4);
        state_d = ST_PP2;
      end
      ST_PP2: begin
        mul_a_c = a_r_q[7:4];
        mul_b_c = b_r_q[3:0];
        acc_d   = acc_q + (pp_ext << 4);
        state_d = ST_PP3;
      end
      ST_PP3: begin
        // Final high-nibble term goes straight into the result register.
        mul_a_c   = a_r_q[7:4];
        mul_b_c   = b_r_q[7:4];
        product_d = acc_q + (pp_ext << 8);
        done_d    = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.mul_a   = mul_a_c;
  assign bus.mul_b   = mul_b_c;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule
